// File: rtl/scale_pkg.sv
// Shared types and constants for the scale sequencer and its address pipeline.
package scale_pkg;

  typedef enum logic [1:0] {
    MODE_1X   = 2'b00,
    MODE_RSVD = 2'b01,
    MODE_WIDE = 2'b10,
    MODE_2X   = 2'b11
  } scale_mode_t;

  localparam int FB_WIDTH  = 240;
  localparam int FB_HEIGHT = 320;
  localparam int FB_ADDR_W = 17;

  // Mode rotation used by the cycle button: 1x -> wide -> 2x -> 1x.
  function automatic scale_mode_t next_mode(input scale_mode_t cur);
    case (cur)
      MODE_1X:   next_mode = MODE_WIDE;
      MODE_WIDE: next_mode = MODE_2X;
      default:   next_mode = MODE_1X;
    endcase
  endfunction

endpackage

// File: rtl/scale_addr_pipe.sv
// Two-stage frame-buffer address pipeline: stage 1 scales the pixel position
// and flags in-region pixels, stage 2 forms sv*FB_WIDTH + sh.
module scale_addr_pipe
  import scale_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  scale_mode_t          mode_in,
  input  logic [10:0]          hcount_in,
  input  logic [9:0]           vcount_in,
  output logic [FB_ADDR_W-1:0] addr_out,
  output logic                 addr_valid_out
);

  logic [7:0]           sh_reg, sh_next;
  logic [8:0]           sv_reg, sv_next;
  logic                 in_reg, in_next;
  logic [FB_ADDR_W-1:0] addr_reg, addr_next;
  logic                 valid_reg;

  // Scale position by the active mode; out-of-region pixels carry zeros.
  always_comb begin
    sh_next = '0;
    sv_next = '0;
    in_next = 1'b0;
    case (mode_in)
      MODE_1X: begin
        in_next = (hcount_in < 11'd240) && (vcount_in < 10'd320);
        sh_next = hcount_in[7:0];
        sv_next = vcount_in[8:0];
      end
      MODE_WIDE: begin
        in_next = (hcount_in < 11'd960) && (vcount_in < 10'd640);
        sh_next = hcount_in[9:2];
        sv_next = vcount_in[9:1];
      end
      MODE_2X: begin
        in_next = (hcount_in < 11'd480) && (vcount_in < 10'd640);
        sh_next = hcount_in[8:1];
        sv_next = vcount_in[9:1];
      end
      default: in_next = 1'b0;
    endcase
    if (!in_next) begin
      sh_next = '0;
      sv_next = '0;
    end
  end

  // Linear address from the stage-1 registers, forced to zero when invalid.
  always_comb begin
    addr_next = '0;
    if (in_reg) begin
      addr_next = FB_ADDR_W'(sv_reg) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(sh_reg);
    end
  end

  // Both pipeline stages, cleared together on reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sh_reg    <= '0;
      sv_reg    <= '0;
      in_reg    <= 1'b0;
      addr_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      sh_reg    <= sh_next;
      sv_reg    <= sv_next;
      in_reg    <= in_next;
      addr_reg  <= addr_next;
      valid_reg <= in_reg;
    end
  end

  assign addr_out       = addr_reg;
  assign addr_valid_out = valid_reg;

endmodule

// File: rtl/scale_sequencer.sv
// Scale-mode sequencer: accepts mode requests, defers them to the next frame
// start, and drives the frame-buffer address pipeline with the active mode.
// Optional feature: define SCALE_SEQ_CYCLE_EN to let cycle_in rotate modes.
module scale_sequencer
  import scale_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [10:0]          hcount_in,
  input  logic [9:0]           vcount_in,
  input  logic                 new_frame_in,
  input  logic                 req_valid_in,
  input  logic [1:0]           req_mode_in,
  output logic                 req_ready_out,
  input  logic                 cycle_in,
  output logic [1:0]           mode_out,
  output logic                 mode_changed_out,
  output logic                 req_err_out,
  output logic [FB_ADDR_W-1:0] addr_out,
  output logic                 addr_valid_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PENDING = 2'b01,
    ST_APPLY   = 2'b10
  } state_t;

  state_t      state_reg, state_next;
  scale_mode_t pending_reg, pending_next;
  scale_mode_t mode_reg, mode_next;
  logic        changed_reg, changed_next;
  logic        err_reg, err_next;
  logic        cycle_req;

`ifdef SCALE_SEQ_CYCLE_EN
  assign cycle_req = cycle_in;
`else
  // Port kept for a stable pinout; the button has no effect in this build.
  logic unused_cycle;
  assign unused_cycle = cycle_in;
  assign cycle_req    = 1'b0;
`endif

  // Next-state and output decode; explicit requests take priority over cycle.
  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg;
    mode_next     = mode_reg;
    changed_next  = 1'b0;
    err_next      = 1'b0;
    req_ready_out = (state_reg == ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (req_valid_in) begin
          if (req_mode_in == MODE_RSVD) begin
            err_next = 1'b1;
          end else begin
            pending_next = scale_mode_t'(req_mode_in);
            state_next   = ST_PENDING;
          end
        end else if (cycle_req) begin
          pending_next = next_mode(mode_reg);
          state_next   = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (new_frame_in) state_next = ST_APPLY;
      end
      ST_APPLY: begin
        mode_next    = pending_reg;
        changed_next = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, pending mode, active mode and status pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_reg   <= ST_IDLE;
      pending_reg <= MODE_1X;
      mode_reg    <= MODE_1X;
      changed_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      mode_reg    <= mode_next;
      changed_reg <= changed_next;
      err_reg     <= err_next;
    end
  end

  assign mode_out         = mode_reg;
  assign mode_changed_out = changed_reg;
  assign req_err_out      = err_reg;

  scale_addr_pipe u_addr_pipe (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .mode_in        (mode_reg),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .addr_out       (addr_out),
    .addr_valid_out (addr_valid_out)
  );

endmodule

// File: tb/tb_scale_sequencer.sv
// Self-checking bench for scale_sequencer: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_scale_sequencer;

`ifdef SCALE_SEQ_CYCLE_EN
  localparam bit CYCLE_EN = 1'b1;
`else
  localparam bit CYCLE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        new_frame = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_mode = '0;
  logic        cycle = 1'b0;
  logic        req_ready;
  logic [1:0]  mode;
  logic        mode_changed;
  logic        req_err;
  logic [16:0] addr;
  logic        addr_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scale_sequencer dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .hcount_in        (hcount),
    .vcount_in        (vcount),
    .new_frame_in     (new_frame),
    .req_valid_in     (req_valid),
    .req_mode_in      (req_mode),
    .req_ready_out    (req_ready),
    .cycle_in         (cycle),
    .mode_out         (mode),
    .mode_changed_out (mode_changed),
    .req_err_out      (req_err),
    .addr_out         (addr),
    .addr_valid_out   (addr_valid)
  );

  // ---------------- reference model ----------------
  // Address of pixel (h,v) in mode m, or -1 when outside the scaled image.
  function automatic int ref_addr(input int h, input int v, input int m);
    int w, ht, dh, dv;
    case (m)
      0:       begin w = 240; ht = 320; dh = 1; dv = 1; end
      2:       begin w = 960; ht = 640; dh = 4; dv = 2; end
      3:       begin w = 480; ht = 640; dh = 2; dv = 2; end
      default: return -1;
    endcase
    if (h >= w || v >= ht) return -1;
    return (v / dv) * 240 + (h / dh);
  endfunction

  function automatic int rotate(input int m);
    case (m)
      0:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  int e_mode = 0, e_changed = 0, e_err = 0, e_addr = 0, e_valid = 0;
  int p1 = -1;         // address computed one edge ago (-1 = invalid)
  bit busy = 0;        // a request is waiting for its frame
  bit apply_due = 0;   // frame seen; mode switches on the next edge
  int want = 0;        // mode waiting to be applied
  bit started = 0;

  always @(posedge clk) begin
    started = 1;
    if (!rst_n) begin
      e_mode = 0; e_changed = 0; e_err = 0; e_addr = 0; e_valid = 0;
      p1 = -1; busy = 0; apply_due = 0; want = 0;
    end else begin
      e_valid = (p1 >= 0);
      e_addr  = (p1 >= 0) ? p1 : 0;
      p1 = ref_addr(int'(hcount), int'(vcount), e_mode);
      e_changed = 0;
      e_err = 0;
      if (apply_due) begin
        e_mode = want; e_changed = 1; apply_due = 0; busy = 0;
      end else if (busy) begin
        if (new_frame) apply_due = 1;
      end else if (req_valid) begin
        if (req_mode == 2'b01) e_err = 1;
        else begin want = int'(req_mode); busy = 1; end
      end else if (CYCLE_EN && cycle) begin
        want = rotate(e_mode); busy = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (int'(mode) != e_mode || int'(mode_changed) != e_changed ||
          int'(req_err) != e_err || req_ready != !busy ||
          int'(addr) != e_addr || int'(addr_valid) != e_valid) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got mode=%0d chg=%0d err=%0d rdy=%0d addr=%0d v=%0d, want mode=%0d chg=%0d err=%0d rdy=%0d addr=%0d v=%0d",
                 $time, mode, mode_changed, req_err, req_ready, addr, addr_valid,
                 e_mode, e_changed, e_err, !busy, e_addr, e_valid);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end else begin
      $display("check %s = %0d", name, got);
    end
  endtask

  task automatic request(input logic [1:0] m, input bit with_frame);
    req_valid = 1'b1; req_mode = m; new_frame = with_frame;
    tick();
    req_valid = 1'b0; new_frame = 1'b0;
  endtask

  task automatic frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  initial begin
    int exp_cyc;
    // reset
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    lit("reset_mode", int'(mode), 0);
    lit("reset_ready", int'(req_ready), 1);
    lit("reset_valid", int'(addr_valid), 0);

    // 1x corner pixel, then first column outside the image
    hcount = 11'd239; vcount = 10'd319;
    tick();
    hcount = 11'd240;
    tick();
    lit("1x_corner_addr", int'(addr), 76799);
    lit("1x_corner_valid", int'(addr_valid), 1);
    tick();
    lit("1x_h240_valid", int'(addr_valid), 0);
    lit("1x_h240_addr", int'(addr), 0);

    // reserved mode request
    request(2'b01, 1'b0);
    lit("rsvd_err", int'(req_err), 1);
    lit("rsvd_mode", int'(mode), 0);
    lit("rsvd_ready", int'(req_ready), 1);
    tick();
    lit("rsvd_err_clear", int'(req_err), 0);

    // 2x request, frame 5 cycles later
    request(2'b11, 1'b0);
    lit("2x_ready_low", int'(req_ready), 0);
    tick(4);
    frame();
    lit("2x_not_yet", int'(mode), 0);
    tick();
    lit("2x_mode", int'(mode), 3);
    lit("2x_changed", int'(mode_changed), 1);
    hcount = 11'd479; vcount = 10'd639;
    tick();
    hcount = 11'd480;
    tick();
    lit("2x_corner_addr", int'(addr), 76799);
    lit("2x_corner_valid", int'(addr_valid), 1);
    tick();
    lit("2x_h480_valid", int'(addr_valid), 0);
    lit("2x_h480_addr", int'(addr), 0);

    // acceptance coinciding with a frame start must wait for the next one
    request(2'b10, 1'b1);
    tick(3);
    lit("samecycle_hold", int'(mode), 3);
    frame();
    tick();
    lit("samecycle_mode", int'(mode), 2);

    // wide-mode address: h=959 -> 239, v=639 -> 319
    hcount = 11'd959; vcount = 10'd639;
    tick(2);
    lit("wide_corner_addr", int'(addr), 76799);

    // pending request discarded by reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    request(2'b10, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lit("rst_ready", int'(req_ready), 1);
    frame();
    tick(2);
    lit("rst_discard_mode", int'(mode), 0);
    lit("rst_discard_chg", int'(mode_changed), 0);

    // cycle button rotation
    for (int i = 0; i < 3; i++) begin
      cycle = 1'b1;
      tick();
      cycle = 1'b0;
      tick();
      frame();
      tick(2);
      exp_cyc = CYCLE_EN ? ((i == 0) ? 2 : (i == 1) ? 3 : 0) : 0;
      lit($sformatf("cycle_step%0d", i), int'(mode), exp_cyc);
    end

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      req_valid = ($urandom_range(0, 7) == 0);
      req_mode  = 2'($urandom_range(0, 3));
      new_frame = ($urandom_range(0, 9) == 0);
      cycle     = ($urandom_range(0, 9) == 0);
      hcount    = 11'($urandom_range(0, 1023));
      vcount    = 10'($urandom_range(0, 700));
      tick();
    end
    rst_n = 1'b1; req_valid = 1'b0; new_frame = 1'b0; cycle = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
